// File: rtl/instr_encoder_if.sv
// Request/response bundle for instr_encoder: encode request in, encoded word and error pulse out.
// The master side issues requests and consumes words; the slave side is the encoder.
interface instr_encoder_if #(
  parameter int ADDR_W = 8
);
  logic              req_valid;
  logic              req_ready;
  logic [2:0]        req_class;
  logic [3:0]        req_alu;
  logic [4:0]        req_rd;
  logic [4:0]        req_rs1;
  logic [4:0]        req_rs2;
  logic [31:0]       req_imm;

  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_instr;
  logic [ADDR_W-1:0] out_addr;

  logic              err_valid;
  logic [1:0]        err_code;

  modport master (
    output req_valid, req_class, req_alu, req_rd, req_rs1, req_rs2, req_imm, out_ready,
    input  req_ready, out_valid, out_instr, out_addr, err_valid, err_code
  );

  modport slave (
    input  req_valid, req_class, req_alu, req_rd, req_rs1, req_rs2, req_imm, out_ready,
    output req_ready, out_valid, out_instr, out_addr, err_valid, err_code
  );
endinterface

// File: rtl/instr_encoder.sv
// Encodes class/alu/reg/imm requests into 32-bit words tagged with a running word address; ENC_RANGE_CHECK_EN enables imm range/alignment rejection.
// Latency 1 into an empty 2-entry FIFO; req_ready is registered and drops only while the FIFO is full.
module instr_encoder #(
  parameter int ADDR_W = 8
) (
  input logic            clk,
  input logic            reset,
  instr_encoder_if.slave bus
);

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LD   = 7'b0000011;
  localparam logic [6:0] OP_ST   = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_CUST = 7'b0001011;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_ILLEGAL = 2'd1;
  localparam logic [1:0] ERR_RANGE   = 2'd2;
  localparam logic [1:0] ERR_ALIGN   = 2'd3;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       instr;
  } entry_t;

  function automatic logic [31:0] fmt_r(input logic [6:0] f7, input logic [2:0] f3,
                                        input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [4:0] rd, input logic [6:0] op);
    return {f7, rs2, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] fmt_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] fmt_s(input logic [11:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [6:0] op);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], op};
  endfunction

  // b holds offset[12:1]; bit 0 of the offset is never encoded
  function automatic logic [31:0] fmt_b(input logic [11:0] b, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [6:0] op);
    return {b[11], b[9:4], rs2, rs1, f3, b[3:0], b[10], op};
  endfunction

  // j holds offset[20:1]
  function automatic logic [31:0] fmt_j(input logic [19:0] j, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {j[19], j[9:0], j[10], j[18:11], rd, op};
  endfunction

`ifdef ENC_RANGE_CHECK_EN
  logic signed [31:0] imm_s;
  logic               fits_12;
  logic               fits_b;
  logic               fits_j;

  assign imm_s   = bus.req_imm;
  assign fits_12 = (imm_s >= -32'sd2048)    && (imm_s <= 32'sd2047);
  assign fits_b  = (imm_s >= -32'sd4096)    && (imm_s <= 32'sd4094);
  assign fits_j  = (imm_s >= -32'sd1048576) && (imm_s <= 32'sd1048574);
`else
  logic unused_imm_hi;
  assign unused_imm_hi = ^bus.req_imm[31:21];
`endif

  logic [31:0] enc_instr;
  logic [1:0]  enc_err;

  always_comb begin
    enc_instr = '0;
    enc_err   = ERR_NONE;
    case (bus.req_class)
      3'd0: begin
        case (bus.req_alu)
          4'd0:    enc_instr = fmt_r(7'b0000000, 3'b000, bus.req_rs2, bus.req_rs1, bus.req_rd, OP_R);
          4'd1:    enc_instr = fmt_r(7'b0100000, 3'b000, bus.req_rs2, bus.req_rs1, bus.req_rd, OP_R);
          4'd2:    enc_instr = fmt_r(7'b0000000, 3'b111, bus.req_rs2, bus.req_rs1, bus.req_rd, OP_R);
          4'd3:    enc_instr = fmt_r(7'b0000000, 3'b110, bus.req_rs2, bus.req_rs1, bus.req_rd, OP_R);
          4'd4:    enc_instr = fmt_r(7'b0000000, 3'b100, bus.req_rs2, bus.req_rs1, bus.req_rd, OP_R);
          default: enc_err   = ERR_ILLEGAL;
        endcase
      end
      3'd1: begin
        enc_instr = fmt_i(bus.req_imm[11:0], bus.req_rs1, 3'b000, bus.req_rd, OP_I);
`ifdef ENC_RANGE_CHECK_EN
        if (!fits_12) enc_err = ERR_RANGE;
`endif
      end
      3'd2: begin
        enc_instr = fmt_i(bus.req_imm[11:0], bus.req_rs1, 3'b010, bus.req_rd, OP_LD);
`ifdef ENC_RANGE_CHECK_EN
        if (!fits_12) enc_err = ERR_RANGE;
`endif
      end
      3'd3: begin
        enc_instr = fmt_s(bus.req_imm[11:0], bus.req_rs2, bus.req_rs1, 3'b010, OP_ST);
`ifdef ENC_RANGE_CHECK_EN
        if (!fits_12) enc_err = ERR_RANGE;
`endif
      end
      3'd4: begin
        enc_instr = fmt_b(bus.req_imm[12:1], bus.req_rs2, bus.req_rs1, 3'b000, OP_BR);
`ifdef ENC_RANGE_CHECK_EN
        if (!fits_b)              enc_err = ERR_RANGE;
        else if (bus.req_imm[0])  enc_err = ERR_ALIGN;
`endif
      end
      3'd5: begin
        enc_instr = fmt_j(bus.req_imm[20:1], bus.req_rd, OP_JAL);
`ifdef ENC_RANGE_CHECK_EN
        if (!fits_j)              enc_err = ERR_RANGE;
        else if (bus.req_imm[0])  enc_err = ERR_ALIGN;
`endif
      end
      3'd6: begin
        // custom ops 8..B map straight onto f3 0..3
        case (bus.req_alu)
          4'd8, 4'd9, 4'd10, 4'd11:
            enc_instr = fmt_r(7'b0000000, bus.req_alu[2:0], bus.req_rs2, bus.req_rs1, bus.req_rd, OP_CUST);
          default: enc_err = ERR_ILLEGAL;
        endcase
      end
      default: enc_err = ERR_ILLEGAL;
    endcase
  end

  entry_t            mem_q [2];
  logic              rd_ptr_q;
  logic              wr_ptr_q;
  logic [1:0]        count_q;
  logic [1:0]        count_d;
  logic              ready_q;
  logic              ready_d;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] addr_d;
  logic              err_valid_q;
  logic              err_valid_d;
  logic [1:0]        err_code_q;
  logic [1:0]        err_code_d;

  logic accept;
  logic illegal;
  logic push;
  logic pop;
  logic fifo_vld;

  assign fifo_vld = (count_q != 2'd0);
  assign accept   = bus.req_valid && ready_q;
  assign illegal  = (enc_err != ERR_NONE);
  assign push     = accept && !illegal;
  assign pop      = fifo_vld && bus.out_ready;

  always_comb begin
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
    ready_d     = (count_d != 2'd2);
    addr_d      = push ? addr_q + ADDR_W'(1) : addr_q;
    err_valid_d = accept && illegal;
    err_code_d  = (accept && illegal) ? enc_err : ERR_NONE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q     <= 2'd0;
      rd_ptr_q    <= 1'b0;
      wr_ptr_q    <= 1'b0;
      ready_q     <= 1'b0;
      addr_q      <= '0;
      err_valid_q <= 1'b0;
      err_code_q  <= ERR_NONE;
    end else begin
      count_q     <= count_d;
      ready_q     <= ready_d;
      addr_q      <= addr_d;
      err_valid_q <= err_valid_d;
      err_code_q  <= err_code_d;
      if (push) wr_ptr_q <= ~wr_ptr_q;
      if (pop)  rd_ptr_q <= ~rd_ptr_q;
    end
  end

  // storage needs no reset: count_q alone decides which slots are valid
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= '{addr: addr_q, instr: enc_instr};
  end

  assign bus.req_ready = ready_q;
  assign bus.out_valid = fifo_vld;
  assign bus.out_instr = mem_q[rd_ptr_q].instr;
  assign bus.out_addr  = mem_q[rd_ptr_q].addr;
  assign bus.err_valid = err_valid_q;
  assign bus.err_code  = err_code_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: expected words queued at request time, compared as the DUT emits them.
module tb_instr_encoder;
  localparam int ADDR_W = 8;

`ifdef ENC_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  instr_encoder_if #(.ADDR_W(ADDR_W)) bus ();
  instr_encoder #(.ADDR_W(ADDR_W)) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    logic [31:0]       instr;
    logic [ADDR_W-1:0] addr;
  } exp_t;

  exp_t              sb[$];
  logic [ADDR_W-1:0] exp_addr;
  bit                exp_err_flag;
  logic [1:0]        exp_err_code;
  int                n_chk = 0;
  int                n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] c, input logic [3:0] a,
                                        input logic [4:0] rd, input logic [4:0] rs1,
                                        input logic [4:0] rs2, input logic [31:0] imm);
    logic [31:0] regs;
    regs = (32'(rs2) << 20) | (32'(rs1) << 15);
    case (c)
      3'd0: case (a)
              4'd0: return regs | (32'(rd) << 7) | 32'h33;
              4'd1: return 32'h4000_0000 | regs | (32'(rd) << 7) | 32'h33;
              4'd2: return regs | 32'h7000 | (32'(rd) << 7) | 32'h33;
              4'd3: return regs | 32'h6000 | (32'(rd) << 7) | 32'h33;
              default: return regs | 32'h4000 | (32'(rd) << 7) | 32'h33;
            endcase
      3'd1: return (32'(imm[11:0]) << 20) | (32'(rs1) << 15) | (32'(rd) << 7) | 32'h13;
      3'd2: return (32'(imm[11:0]) << 20) | (32'(rs1) << 15) | 32'h2000 | (32'(rd) << 7) | 32'h03;
      3'd3: return (32'(imm[11:5]) << 25) | regs | 32'h2000 | (32'(imm[4:0]) << 7) | 32'h23;
      3'd4: return (32'(imm[12]) << 31) | (32'(imm[10:5]) << 25) | regs |
                   (32'(imm[4:1]) << 8) | (32'(imm[11]) << 7) | 32'h63;
      3'd5: return (32'(imm[20]) << 31) | (32'(imm[10:1]) << 21) | (32'(imm[11]) << 20) |
                   (32'(imm[19:12]) << 12) | (32'(rd) << 7) | 32'h6F;
      default: return regs | (32'(a[1:0]) << 12) | (32'(rd) << 7) | 32'h0B;
    endcase
  endfunction

  // Monitor: error pulse, hold-while-stalled, and in-order scoreboard pops.
  bit                hold_vld;
  logic [31:0]       hold_instr;
  logic [ADDR_W-1:0] hold_addr;

  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      hold_vld     = 1'b0;
      exp_err_flag = 1'b0;
    end else begin
      chk("err_valid", 32'(bus.err_valid), 32'(exp_err_flag));
      if (exp_err_flag) chk("err_code", 32'(bus.err_code), 32'(exp_err_code));
      exp_err_flag = 1'b0;
      if (hold_vld) begin
        chk("hold_valid", 32'(bus.out_valid), 32'd1);
        chk("hold_instr", bus.out_instr, hold_instr);
        chk("hold_addr", 32'(bus.out_addr), 32'(hold_addr));
      end
      hold_vld   = bus.out_valid && !bus.out_ready;
      hold_instr = bus.out_instr;
      hold_addr  = bus.out_addr;
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_word", bus.out_instr, 32'h0);
        end else begin
          e = sb.pop_front();
          chk("out_instr", bus.out_instr, e.instr);
          chk("out_addr", 32'(bus.out_addr), 32'(e.addr));
        end
      end
    end
  end

  // Call at posedge+1; returns at posedge+1 right after the accepting edge.
  task automatic send(input logic [2:0] c, input logic [3:0] a, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm,
                      input logic [1:0] ecode, input logic [31:0] einstr);
    exp_t e;
    int   t = 0;
    bus.req_valid = 1'b1;
    bus.req_class = c;
    bus.req_alu   = a;
    bus.req_rd    = rd;
    bus.req_rs1   = rs1;
    bus.req_rs2   = rs2;
    bus.req_imm   = imm;
    @(negedge clk);
    while (!bus.req_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!bus.req_ready) begin
      chk("accept_timeout", 32'd0, 32'd1);
      bus.req_valid = 1'b0;
      return;
    end
    if (ecode == 2'd0) begin
      e.instr = einstr;
      e.addr  = exp_addr;
      sb.push_back(e);
      exp_addr = exp_addr + 1'b1;
    end
    @(posedge clk);
    #1;
    if (ecode != 2'd0) begin
      exp_err_flag = 1'b1;
      exp_err_code = ecode;
    end
    bus.req_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while ((sb.size() != 0 || bus.out_valid) && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("drain", 32'(sb.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  c;
    logic [3:0]  a;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;

    bus.req_valid = 1'b0;
    bus.req_class = '0;
    bus.req_alu   = '0;
    bus.req_rd    = '0;
    bus.req_rs1   = '0;
    bus.req_rs2   = '0;
    bus.req_imm   = '0;
    bus.out_ready = 1'b1;
    exp_addr      = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_err_valid", 32'(bus.err_valid), 32'd0);
    chk("rst_err_code", 32'(bus.err_code), 32'd0);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_req_ready_held", 32'(bus.req_ready), 32'd0);
    @(negedge clk);
    chk("ready_after_rst", 32'(bus.req_ready), 32'd1);
    chk("idle_out_valid", 32'(bus.out_valid), 32'd0);
    @(posedge clk); #1;

    // SUB x3,x1,x2 at address 0, visible one cycle after acceptance
    send(3'd0, 4'd1, 5'd3, 5'd1, 5'd2, 32'd0, 2'd0, 32'h402081B3);
    @(negedge clk);
    chk("latency1_valid", 32'(bus.out_valid), 32'd1);
    chk("first_addr", 32'(bus.out_addr), 32'd0);
    @(posedge clk); #1;

    // Directed encodings back-to-back (also exercises push+pop at occupancy 1)
    send(3'd1, 4'd15, 5'd1, 5'd0, 5'd0, 32'hFFFF_FFFF, 2'd0, 32'hFFF00093);
    send(3'd6, 4'd9, 5'd5, 5'd6, 5'd7, 32'd0, 2'd0, 32'h0073128B);
    send(3'd0, 4'd2, 5'd1, 5'd2, 5'd3, 32'd0, 2'd0, 32'h003170B3);
    send(3'd2, 4'd0, 5'd3, 5'd4, 5'd0, 32'd12, 2'd0, 32'h00C22183);
    send(3'd3, 4'd0, 5'd0, 5'd2, 5'd5, 32'd8, 2'd0, 32'h00512423);
    send(3'd4, 4'd0, 5'd0, 5'd1, 5'd2, 32'd8, 2'd0, 32'h00208463);
    send(3'd5, 4'd0, 5'd1, 5'd0, 5'd0, 32'd16, 2'd0, 32'h010000EF);
    drain();

    // Backpressure: two fill the FIFO, ready drops, third waits for release
    bus.out_ready = 1'b0;
    send(3'd0, 4'd3, 5'd4, 5'd5, 5'd6, 32'd0, 2'd0, model(3'd0, 4'd3, 5'd4, 5'd5, 5'd6, 32'd0));
    send(3'd0, 4'd4, 5'd7, 5'd8, 5'd9, 32'd0, 2'd0, model(3'd0, 4'd4, 5'd7, 5'd8, 5'd9, 32'd0));
    @(negedge clk);
    chk("full_req_ready", 32'(bus.req_ready), 32'd0);
    chk("full_out_valid", 32'(bus.out_valid), 32'd1);
    repeat (2) @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    send(3'd0, 4'd0, 5'd10, 5'd11, 5'd12, 32'd0, 2'd0, model(3'd0, 4'd0, 5'd10, 5'd11, 5'd12, 32'd0));
    drain();

    // Out-of-range / odd offsets: rejected with the check, truncated without it
    send(3'd1, 4'd0, 5'd2, 5'd0, 5'd0, 32'd2048, RC ? 2'd2 : 2'd0, 32'h80000113);
    send(3'd3, 4'd0, 5'd0, 5'd0, 5'd0, 32'hFFFF_F7FF, RC ? 2'd2 : 2'd0, 32'h7E002FA3);
    send(3'd4, 4'd0, 5'd0, 5'd1, 5'd2, 32'd9, RC ? 2'd3 : 2'd0, 32'h00208463);
    send(3'd5, 4'd0, 5'd1, 5'd0, 5'd0, 32'd1048576, RC ? 2'd2 : 2'd0, 32'h800000EF);
    send(3'd1, 4'd0, 5'd1, 5'd0, 5'd0, 32'd5, 2'd0, 32'h00500093);

    // Illegal class / alu codes never consume an address
    send(3'd7, 4'd0, 5'd1, 5'd1, 5'd1, 32'd0, 2'd1, 32'd0);
    send(3'd0, 4'd7, 5'd1, 5'd1, 5'd1, 32'd0, 2'd1, 32'd0);
    send(3'd6, 4'd3, 5'd1, 5'd1, 5'd1, 32'd0, 2'd1, 32'd0);
    send(3'd0, 4'd0, 5'd31, 5'd30, 5'd29, 32'd0, 2'd0, model(3'd0, 4'd0, 5'd31, 5'd30, 5'd29, 32'd0));
    drain();

    // Reset with two words buffered: both must vanish
    bus.out_ready = 1'b0;
    send(3'd1, 4'd0, 5'd1, 5'd1, 5'd0, 32'd1, 2'd0, 32'd0);
    send(3'd1, 4'd0, 5'd2, 5'd2, 5'd0, 32'd2, 2'd0, 32'd0);
    @(negedge clk);
    chk("pre_rst_ready", 32'(bus.req_ready), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    sb.delete();
    exp_addr = '0;
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_req_ready", 32'(bus.req_ready), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("post_rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("post_rst_req_ready", 32'(bus.req_ready), 32'd1);
    @(posedge clk); #1;

    // 257 legal requests: addresses 0..255 then wrap to 0
    for (int i = 0; i < 257; i++) begin
      c   = 3'($urandom_range(0, 6));
      a   = 4'($urandom_range(0, 15));
      rd  = 5'($urandom_range(0, 31));
      rs1 = 5'($urandom_range(0, 31));
      rs2 = 5'($urandom_range(0, 31));
      imm = $urandom;
      case (c)
        3'd0: a = 4'($urandom_range(0, 4));
        3'd6: a = 4'($urandom_range(8, 11));
        3'd1, 3'd2, 3'd3: imm = 32'(int'($urandom_range(0, 4095)) - 2048);
        3'd4: imm = 32'(2 * (int'($urandom_range(0, 4095)) - 2048));
        3'd5: imm = 32'(2 * (int'($urandom_range(0, 1048575)) - 524288));
        default: ;
      endcase
      send(c, a, rd, rs1, rs2, imm, 2'd0, model(c, a, rd, rs1, rs2, imm));
      if (i == 255) begin
        @(negedge clk);
        chk("last_addr_255", 32'(bus.out_addr), 32'd255);
        @(posedge clk); #1;
      end
    end
    @(negedge clk);
    chk("wrap_addr_0", 32'(bus.out_addr), 32'd0);
    @(posedge clk); #1;
    drain();
    chk("end_out_valid", 32'(bus.out_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
